// File: rtl/ser_pkg.sv
// Constants and types shared by the serializer / deserializer pair.
// Both ends of the link import this so frame sizing cannot drift apart.
package ser_pkg;

    localparam int SER_WIDTH    = 16;
    localparam int SER_MIN_BITS = 3;

    typedef logic [SER_WIDTH-1:0]         ser_word_t;
    typedef logic [$clog2(SER_WIDTH)-1:0] ser_mod_t;

    // Width of the "bit count mod WIDTH" field for a given word width.
    function automatic int ser_mod_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// Two-entry ready/valid FIFO holding {word, mod} for the deserializer.
// Outputs come straight from registers; the head reads 0 whenever the FIFO is empty.
module deser_out_buf
    import ser_pkg::*;
#(
    parameter int DW = SER_WIDTH + ser_mod_bits(SER_WIDTH)
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          ready_i,
    output logic          full_o,
    output logic          pop_o,
    output logic          val_o,
    output logic [DW-1:0] data_o
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q,  head_d;
    logic [DW-1:0] tail_q,  tail_d;
    logic          pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop     = (count_q != 2'd0) && ready_i;

        unique case (count_q)
            2'd0: begin
                if (push_i) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop) begin
                    head_d = push_data_i;
                end else if (pop) begin
                    head_d  = '0;
                    count_d = 2'd0;
                end else if (push_i) begin
                    tail_d  = push_data_i;
                    count_d = 2'd2;
                end
            end
            default: begin
                // Full: a push is only taken when the head leaves in the same cycle.
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                    end else begin
                        tail_d  = '0;
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: both storage slots are reset (not just count) because the head drives the outputs and must read 0.
        if (srst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign full_o = (count_q == 2'd2);
    assign pop_o  = pop;
    assign val_o  = (count_q != 2'd0);
    assign data_o = head_q;

endmodule

// File: rtl/deserializer.sv
// Packs an MSB-first serial stream into left-aligned words with a bit count,
// flagging runt frames and words dropped because the output buffer was full.
module deserializer
    import ser_pkg::*;
#(
    parameter int WIDTH    = SER_WIDTH,
    parameter int MIN_BITS = SER_MIN_BITS
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     ser_data_i,
    input  logic                     ser_data_val_i,
    output logic [WIDTH-1:0]         deser_data_o,
    output logic [$clog2(WIDTH)-1:0] deser_data_mod_o,
    output logic                     deser_data_val_o,
    input  logic                     deser_data_ready_i,
    output logic                     overflow_o,
    output logic                     runt_o
);

    localparam int MW = $clog2(WIDTH);
    localparam int CW = MW + 1;
    localparam int DW = WIDTH + MW;

    logic [WIDTH-1:0] sr_q,   sr_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             runt_q, runt_d;
    logic             ovf_q,  ovf_d;
    logic [MW-1:0]    bit_idx;

    logic             push;
    logic [WIDTH-1:0] push_word;
    logic [MW-1:0]    push_mod;
    logic             buf_full;
    logic             buf_pop;
    logic [DW-1:0]    buf_data;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        runt_d    = 1'b0;
        push      = 1'b0;
        push_word = sr_q;
        push_mod  = cnt_q[MW-1:0];
        bit_idx   = MW'(WIDTH - 1) - cnt_q[MW-1:0];

        if (ser_data_val_i) begin
            sr_d[bit_idx] = ser_data_i;
            if (cnt_q == CW'(WIDTH - 1)) begin
                // Last bit of a full word: push it now so a new frame can start next cycle.
                push      = 1'b1;
                push_word = sr_d;
                push_mod  = '0;
                sr_d      = '0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cnt_q != '0) begin
            if (cnt_q < CW'(MIN_BITS)) begin
                runt_d = 1'b1;
            end else begin
                push = 1'b1;
            end
            sr_d  = '0;
            cnt_d = '0;
        end

        ovf_d = push && buf_full && !buf_pop;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (srst_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            runt_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            runt_q <= runt_d;
            ovf_q  <= ovf_d;
        end
    end

    deser_out_buf #(
        .DW (DW)
    ) u_out_buf (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .push_i      (push),
        .push_data_i ({push_word, push_mod}),
        .ready_i     (deser_data_ready_i),
        .full_o      (buf_full),
        .pop_o       (buf_pop),
        .val_o       (deser_data_val_o),
        .data_o      (buf_data)
    );

    assign deser_data_o     = buf_data[DW-1:MW];
    assign deser_data_mod_o = buf_data[MW-1:0];
    assign runt_o           = runt_q;
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus a randomized run
// scored against a frame/queue-level reference model.
module tb_deserializer;

    localparam int W   = 16;
    localparam int MW  = 4;
    localparam int MIN = 3;

    logic          clk = 1'b0;
    logic          srst_i = 1'b1;
    logic          ser_data_i = 1'b0;
    logic          ser_data_val_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          deser_data_ready_i = 1'b0;
    logic          overflow_o;
    logic          runt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [W-1:0]  word;
        logic [MW-1:0] mod;
    } entry_t;

    logic   bits_q[$];
    entry_t fifo_q[$];

    logic          exp_val;
    logic [W-1:0]  exp_data;
    logic [MW-1:0] exp_mod;
    logic          exp_runt;
    logic          exp_ovf;

    always #5 clk = ~clk;

    deserializer #(
        .WIDTH    (W),
        .MIN_BITS (MIN)
    ) dut (
        .clk_i              (clk),
        .srst_i             (srst_i),
        .ser_data_i         (ser_data_i),
        .ser_data_val_i     (ser_data_val_i),
        .deser_data_o       (deser_data_o),
        .deser_data_mod_o   (deser_data_mod_o),
        .deser_data_val_o   (deser_data_val_o),
        .deser_data_ready_i (deser_data_ready_i),
        .overflow_o         (overflow_o),
        .runt_o             (runt_o)
    );

    // Drive one cycle of inputs, advance the reference model, and return 1ns after the edge.
    task automatic step(input logic v, input logic d, input logic rdy, input logic rst);
        bit     pop;
        bit     was_full;
        bit     have;
        entry_t e;
        int     n;

        srst_i             = rst;
        ser_data_val_i     = v;
        ser_data_i         = d;
        deser_data_ready_i = rdy;

        exp_runt = 1'b0;
        exp_ovf  = 1'b0;
        if (rst) begin
            bits_q.delete();
            fifo_q.delete();
        end else begin
            pop      = (fifo_q.size() > 0) && rdy;
            was_full = (fifo_q.size() == 2);
            have     = 1'b0;
            n        = 0;
            if (v) begin
                bits_q.push_back(d);
                if (bits_q.size() == W) n = W;
            end else if (bits_q.size() > 0) begin
                n = bits_q.size();
            end
            if (n > 0) begin
                if (n < MIN) begin
                    exp_runt = 1'b1;
                end else begin
                    e.word = '0;
                    for (int i = 0; i < n; i++) e.word[W-1-i] = bits_q[i];
                    e.mod = MW'(n % W);
                    have  = 1'b1;
                end
                bits_q.delete();
            end
            if (pop) void'(fifo_q.pop_front());
            if (have) begin
                if (was_full && !pop) exp_ovf = 1'b1;
                else fifo_q.push_back(e);
            end
        end
        exp_val  = (fifo_q.size() > 0);
        exp_data = exp_val ? fifo_q[0].word : '0;
        exp_mod  = exp_val ? fifo_q[0].mod  : '0;

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        tests_run += 5;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL reset_val: got %b expected 0", deser_data_val_o); end
        if (deser_data_o !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", deser_data_o); end
        if (deser_data_mod_o !== '0) begin tests_failed++; $display("FAIL reset_mod: got %0d expected 0", deser_data_mod_o); end
        if (runt_o !== 1'b0) begin tests_failed++; $display("FAIL reset_runt: got %b expected 0", runt_o); end
        if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    endtask

    task automatic test_full_word;
        logic [W-1:0] w;
        w = 16'hA5C3;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, w[W-1-i], 1'b1, 1'b0);
        tests_run += 3;
        if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL full_val: got %b expected 1", deser_data_val_o); end
        if (deser_data_o !== 16'hA5C3) begin tests_failed++; $display("FAIL full_data: got %h expected a5c3", deser_data_o); end
        if (deser_data_mod_o !== 4'd0) begin tests_failed++; $display("FAIL full_mod: got %0d expected 0", deser_data_mod_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL full_val_drop: got %b expected 0", deser_data_val_o); end
        if (deser_data_o !== '0) begin tests_failed++; $display("FAIL full_data_idle: got %h expected 0000", deser_data_o); end
    endtask

    task automatic test_short_frame;
        logic [4:0] b;
        b = 5'b10110;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, b[4-i], 1'b1, 1'b0);
        tests_run += 1;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL short_early: got %b expected 0", deser_data_val_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 3;
        if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL short_val: got %b expected 1", deser_data_val_o); end
        if (deser_data_o !== 16'hB000) begin tests_failed++; $display("FAIL short_data: got %h expected b000", deser_data_o); end
        if (deser_data_mod_o !== 4'd5) begin tests_failed++; $display("FAIL short_mod: got %0d expected 5", deser_data_mod_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 1;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL short_val_drop: got %b expected 0", deser_data_val_o); end
    endtask

    task automatic test_runt;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (runt_o !== 1'b1) begin tests_failed++; $display("FAIL runt_pulse: got %b expected 1", runt_o); end
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL runt_val: got %b expected 0", deser_data_val_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (runt_o !== 1'b0) begin tests_failed++; $display("FAIL runt_width: got %b expected 0", runt_o); end
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL runt_val_late: got %b expected 0", deser_data_val_o); end
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] s;
        s = {16'h1234, 16'hFFFF};
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2 * W; i++) begin
            step(1'b1, s[2*W-1-i], 1'b1, 1'b0);
            if (i == W - 1) begin
                tests_run += 2;
                if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_val0: got %b expected 1", deser_data_val_o); end
                if (deser_data_o !== 16'h1234) begin tests_failed++; $display("FAIL b2b_word0: got %h expected 1234", deser_data_o); end
            end
            if (i == W) begin
                tests_run += 1;
                if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got %b expected 0", deser_data_val_o); end
            end
        end
        tests_run += 3;
        if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_val1: got %b expected 1", deser_data_val_o); end
        if (deser_data_o !== 16'hFFFF) begin tests_failed++; $display("FAIL b2b_word1: got %h expected ffff", deser_data_o); end
        if (deser_data_mod_o !== 4'd0) begin tests_failed++; $display("FAIL b2b_mod1: got %0d expected 0", deser_data_mod_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall;
        logic [W-1:0] w [3];
        for (int f = 0; f < 3; f++) w[f] = W'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W; i++) step(1'b1, w[f][W-1-i], 1'b0, 1'b0);
            if (f == 1) begin
                tests_run += 2;
                if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL stall_no_ovf: got %b expected 0", overflow_o); end
                if (deser_data_o !== w[0]) begin tests_failed++; $display("FAIL stall_head2: got %h expected %h", deser_data_o, w[0]); end
            end
        end
        tests_run += 2;
        if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL stall_ovf: got %b expected 1", overflow_o); end
        if (deser_data_o !== w[0]) begin tests_failed++; $display("FAIL stall_head3: got %h expected %h", deser_data_o, w[0]); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tests_run += 2;
        if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL stall_ovf_width: got %b expected 0", overflow_o); end
        if (deser_data_o !== w[0]) begin tests_failed++; $display("FAIL stall_hold: got %h expected %h", deser_data_o, w[0]); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL stall_val2: got %b expected 1", deser_data_val_o); end
        if (deser_data_o !== w[1]) begin tests_failed++; $display("FAIL stall_word2: got %h expected %h", deser_data_o, w[1]); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run += 2;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL stall_drained: got %b expected 0", deser_data_val_o); end
        if (deser_data_o !== '0) begin tests_failed++; $display("FAIL stall_data_idle: got %h expected 0000", deser_data_o); end
    endtask

    task automatic test_reset_mid_frame;
        logic [W-1:0] w;
        int           runt_seen;
        w = 16'h8001;
        runt_seen = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        tests_run += 4;
        if (deser_data_val_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_val: got %b expected 0", deser_data_val_o); end
        if (deser_data_o !== '0) begin tests_failed++; $display("FAIL rmid_data: got %h expected 0000", deser_data_o); end
        if (runt_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_runt: got %b expected 0", runt_o); end
        if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_ovf: got %b expected 0", overflow_o); end
        for (int i = 0; i < W; i++) begin
            step(1'b1, w[W-1-i], 1'b1, 1'b0);
            if (runt_o !== 1'b0) runt_seen++;
        end
        tests_run += 4;
        if (runt_seen != 0) begin tests_failed++; $display("FAIL rmid_runt_after: got %0d pulses expected 0", runt_seen); end
        if (deser_data_val_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_val_new: got %b expected 1", deser_data_val_o); end
        if (deser_data_o !== 16'h8001) begin tests_failed++; $display("FAIL rmid_word: got %h expected 8001", deser_data_o); end
        if (deser_data_mod_o !== 4'd0) begin tests_failed++; $display("FAIL rmid_mod: got %0d expected 0", deser_data_mod_o); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic v, d, rdy, rst;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 2000; c++) begin
            v   = ($urandom_range(0, 9) < 8);
            d   = 1'($urandom);
            rdy = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 199) == 0);
            step(v, d, rdy, rst);
            tests_run += 5;
            if (deser_data_val_o !== exp_val) begin tests_failed++; $display("FAIL rand_val @%0d: got %b expected %b", c, deser_data_val_o, exp_val); end
            if (deser_data_o !== exp_data) begin tests_failed++; $display("FAIL rand_data @%0d: got %h expected %h", c, deser_data_o, exp_data); end
            if (deser_data_mod_o !== exp_mod) begin tests_failed++; $display("FAIL rand_mod @%0d: got %0d expected %0d", c, deser_data_mod_o, exp_mod); end
            if (runt_o !== exp_runt) begin tests_failed++; $display("FAIL rand_runt @%0d: got %b expected %b", c, runt_o, exp_runt); end
            if (overflow_o !== exp_ovf) begin tests_failed++; $display("FAIL rand_ovf @%0d: got %b expected %b", c, overflow_o, exp_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_frame();
        test_runt();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel stage that sits directly downstream of the team's `serializer`. It accepts a 1-bit MSB-first stream qualified by a valid strobe and packs each frame into a left-aligned `WIDTH`-bit word with a bit count. It delivers words through a 2-entry ready/valid output buffer, so a stalled consumer does not lose data unless the buffer overflows.

## Interface
- `WIDTH`, default 16, word width in bits; must be ≥ 4 and a power of 2.
- `MIN_BITS`, default 3, shortest legal frame in bits; shorter frames are runts.
- `clk_i`  in  1  single clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `ser_data_i`  in  1  serial bit, MSB first.
- `ser_data_val_i`  in  1  `ser_data_i` is valid this cycle; a frame is a contiguous run of valid cycles.
- `deser_data_o`  out  `WIDTH`  frame bits left-aligned (first bit at `[WIDTH-1]`), unused LSBs 0.
- `deser_data_mod_o`  out  `$clog2(WIDTH)`  bit count mod `WIDTH`; 0 means `WIDTH` bits.
- `deser_data_val_o`  out  1  head-of-buffer word valid.
- `deser_data_ready_i`  in  1  consumer accepts the word when `val && ready`.
- `overflow_o`  out  1  one-cycle pulse: completed word dropped because the buffer was full.
- `runt_o`  out  1  one-cycle pulse: frame shorter than `MIN_BITS` discarded.

## Operation
- **Collector:**
  - Shift register `sr[WIDTH-1:0]` and bit counter `cnt` (0..`WIDTH`).
  - Each valid cycle: `sr[WIDTH-1-cnt] <= ser_data_i`, then `cnt++`.
- **Frame terminates when either:**
  - (a) `cnt` reaches `WIDTH` on a valid bit (full word), or
  - (b) `ser_data_val_i` is low while `cnt > 0` (short word).
- **On termination:**
  - If `cnt < MIN_BITS`: pulse `runt_o` and push nothing.
  - Otherwise push `{sr, cnt mod WIDTH}` into the output buffer.
  - Then clear `sr` and `cnt`.
- **Back-to-back full frames:** after (a), a valid bit in the next cycle starts a new frame; no idle gap is required.
- **Output buffer** (2 entries, FIFO order):
  - Pop on `deser_data_val_o && deser_data_ready_i`.
  - Push while full with no pop in the same cycle: drop the new word and pulse `overflow_o`. The buffer keeps its contents.
  - Push and pop in the same cycle while full: accepted; occupancy stays 2.
  - Push into empty: the word appears on outputs the next cycle.
- **Outputs when `deser_data_val_o` = 0:** `deser_data_o` and `deser_data_mod_o` hold 0.
- **Reset:**
  - All outputs go to 0; buffer empty; `cnt` = 0; `sr` = 0.
  - A partial frame in progress is discarded silently, with no `runt_o`.

## Timing
- **Full word:** `deser_data_val_o` rises in the cycle after the `WIDTH`-th valid bit (1-cycle latency), provided the buffer is empty.
- **Short word:** the first invalid cycle terminates the frame, and `deser_data_val_o` rises in the cycle after that (2 cycles after the last bit).
- **`runt_o` and `overflow_o`:** registered, high for exactly the one cycle after the terminating cycle.
- **Ready path:** `deser_data_ready_i` has no combinational path to any output. Throughput is 1 word per cycle sustained.
- **Reset mid-operation:** `srst_i` wins over every simultaneous push, pop or bit. Outputs read 0 in the cycle after the reset edge.

## Structure
- **Package `ser_pkg`:**
  - Default `WIDTH`.
  - `typedef logic [WIDTH-1:0] ser_word_t`.
  - `typedef logic [$clog2(WIDTH)-1:0] ser_mod_t`.
  - Constant `SER_MIN_BITS` = 3; `serializer` and `deserializer` share it.
- **Sub-module `deser_out_buf`:** 2-entry ready/valid FIFO carrying `{word, mod}`, with inputs push/full and outputs for the overflow decision.
- **Top level:** holds the collector and the runt/overflow pulse registers.

## Test plan
- **Full word:** 16 valid bits encoding 0xA5C3, ready = 1 → one cycle later `deser_data_o` = 0xA5C3, `mod` = 0, `val` high for 1 cycle.
- **Short frame:** 5 bits 1,0,1,1,0 then val low → `deser_data_o` = 0xB000, `mod` = 5, `val` rises 2 cycles after the last bit.
- **Runt:** 2 bits then idle → `runt_o` pulses once; `deser_data_val_o` stays 0.
- **Back-to-back:** 0x1234 then immediately 0xFFFF (32 consecutive valid cycles), ready = 1 → two words in order on consecutive-cycle boundaries; no gap required.
- **Stall:** ready = 0 while 3 full frames arrive → first two words are held; third drop pulses `overflow_o`. Raising ready then yields words 1 and 2 in order with nothing else.
- **Reset mid-frame:** `srst_i` for 1 cycle after 7 bits of a frame, then a fresh 16-bit 0x8001 → all outputs 0 the cycle after reset. Only 0x8001 is produced, with `mod` = 0 and no runt.
